// File: rtl/clkdiv_mc_if.sv
// Control/status bundle for the multi-channel clock divider clkdiv_mc.
// The DIV_TICK strobe vector exists only when CLKDIV_MC_TICK_EN is defined.
interface clkdiv_mc_if #(
  parameter int NUM_CH      = 2,
  parameter int RATIO_WIDTH = 8
);
  logic [NUM_CH-1:0]             clk_en;
  logic [NUM_CH*RATIO_WIDTH-1:0] div_ratio;
  logic [NUM_CH-1:0]             ratio_ld;
  logic [NUM_CH-1:0]             div_clk;
  logic [NUM_CH-1:0]             ratio_pend;
  logic [NUM_CH-1:0]             ratio_upd;
`ifdef CLKDIV_MC_TICK_EN
  logic [NUM_CH-1:0]             div_tick;
`endif

  // ratio_ld is a single-cycle strobe sampled on the source clock posedge;
  // there is no back-pressure, every strobe is captured.
  modport master (
    output clk_en, div_ratio, ratio_ld,
    input  div_clk, ratio_pend, ratio_upd
`ifdef CLKDIV_MC_TICK_EN
    , input div_tick
`endif
  );

  modport slave (
    input  clk_en, div_ratio, ratio_ld,
    output div_clk, ratio_pend, ratio_upd
`ifdef CLKDIV_MC_TICK_EN
    , output div_tick
`endif
  );
endinterface

// File: rtl/clkdiv_mc.sv
// NUM_CH independent integer clock dividers with shadowed, boundary-aligned ratio updates.
// Define CLKDIV_MC_TICK_EN to add the registered per-channel DIV_TICK clock-enable output.
module clkdiv_mc #(
  parameter int NUM_CH      = 2,
  parameter int RATIO_WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  clkdiv_mc_if.slave  bus
);
  localparam int W = RATIO_WIDTH;
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  logic [NUM_CH-1:0] div_clk_w;
  logic [NUM_CH-1:0] pend_w;
  logic [NUM_CH-1:0] upd_w;
`ifdef CLKDIV_MC_TICK_EN
  logic [NUM_CH-1:0] tick_w;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [W-1:0] r_act_q, r_act_d;
    logic [W-1:0] r_pnd_q, r_pnd_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         pend_q, pend_d;
    logic         div_q, div_d;
    logic         upd_q, upd_d;
    logic         tick_q, tick_d;
    logic [W-1:0] slice, app_val, low_len, high_len;
    logic         en, ld, active, low_done, high_done, boundary, apply;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_act_q <= '0;
        r_pnd_q <= '0;
        cnt_q   <= '0;
        pend_q  <= 1'b0;
        div_q   <= 1'b0;
        upd_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        r_act_q <= r_act_d;
        r_pnd_q <= r_pnd_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
        div_q   <= div_d;
        upd_q   <= upd_d;
        tick_q  <= tick_d;
      end
    end

    always_comb begin
      en        = bus.clk_en[g];
      ld        = bus.ratio_ld[g];
      slice     = bus.div_ratio[g*W +: W];
      active    = en && (r_act_q >= TWO);
      low_len   = r_act_q - (r_act_q >> 1);
      high_len  = r_act_q >> 1;
      low_done  = !div_q && (cnt_q == low_len - ONE);
      high_done = div_q && (cnt_q == high_len - ONE);
      boundary  = active && high_done;
      // A strobe on the boundary edge wins over an older pending ratio.
      app_val   = ld ? slice : r_pnd_q;
      apply     = (ld || pend_q) && (!active || boundary);

      r_act_d = r_act_q;
      r_pnd_d = ld ? slice : r_pnd_q;
      pend_d  = ld || pend_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      upd_d   = apply;
      tick_d  = en && (apply ? (app_val < TWO) : (!active || low_done));

      if (apply) begin
        r_act_d = app_val;
        pend_d  = 1'b0;
        cnt_d   = '0;
        div_d   = 1'b0;
      end else if (!active) begin
        cnt_d = '0;
        div_d = 1'b0;
      end else if (low_done || high_done) begin
        cnt_d = '0;
        div_d = !div_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end

    // clk_en is expected to change synchronously to clk_i, so the mux only
    // swaps sources right after a posedge.
    assign div_clk_w[g] = active ? div_q : clk_i;
    assign pend_w[g]    = pend_q;
    assign upd_w[g]     = upd_q;
`ifdef CLKDIV_MC_TICK_EN
    assign tick_w[g]    = tick_q;
`endif
  end

  assign bus.div_clk    = div_clk_w;
  assign bus.ratio_pend = pend_w;
  assign bus.ratio_upd  = upd_w;
`ifdef CLKDIV_MC_TICK_EN
  assign bus.div_tick   = tick_w;
`endif
endmodule
